// File: rtl/transpose_pkg.sv
// ---------------------------------------------------------------------------
// transpose_pkg: shared types and index-width helper for the transpose buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package transpose_pkg;

  localparam int DEFAULT_DIM  = 8;
  localparam int DEFAULT_BITS = 64;

  typedef logic signed [DEFAULT_BITS-1:0] elem_t;
  typedef elem_t vec_t [0:DEFAULT_DIM-1];

  function automatic int idx_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/transpose_bank.sv
// ---------------------------------------------------------------------------
// transpose_bank: DIM x DIM register tile, row write port, row/column read mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module transpose_bank
  import transpose_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int BITS  = 64,
  parameter int IDX_W = idx_w(DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic signed [BITS-1:0] wr_vec [0:DIM-1],
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic                   xpose,
  output logic signed [BITS-1:0] rd_vec [0:DIM-1]
);

  logic signed [BITS-1:0] mem [0:DIM-1][0:DIM-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < DIM; c++) begin
        mem[wr_idx][c] <= wr_vec[c];
      end
    end
  end

  // Transposed mode reads column rd_idx; pass-through reads row rd_idx.
  generate
    for (genvar r = 0; r < DIM; r++) begin : g_rd_lane
      assign rd_vec[r] = xpose ? mem[r][rd_idx] : mem[rd_idx][r];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/transpose_buffer.sv
// ---------------------------------------------------------------------------
// transpose_buffer: double-buffered DIM x DIM tile transpose / pass-through
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module transpose_buffer
  import transpose_pkg::*;
#(
  parameter int DIM  = 8,
  parameter int BITS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] in_row [0:DIM-1],
  input  logic                   in_xpose,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BITS-1:0] out_col [0:DIM-1],
  output logic                   out_last,
  output logic [1:0]             full_cnt
);

  localparam int               IDX_W = idx_w(DIM);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DIM - 1);

  logic [1:0]             full;
  logic [1:0]             xpose;
  logic                   wb;
  logic                   rb;
  logic [IDX_W-1:0]       wr_row;
  logic [IDX_W-1:0]       rd_idx;
  logic                   accept;
  logic                   take;
  logic signed [BITS-1:0] vec0 [0:DIM-1];
  logic signed [BITS-1:0] vec1 [0:DIM-1];

  assign in_ready  = !full[wb];
  assign out_valid = full[rb];
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign out_last  = out_valid && (rd_idx == LAST);
  assign full_cnt  = {1'b0, full[0]} + {1'b0, full[1]};

  // On a tile boundary wb != rb, so the set and clear below hit different bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      xpose  <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
      rd_idx <= '0;
    end else if (clr) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
      rd_idx <= '0;
    end else begin
      if (accept) begin
        if (wr_row == '0) xpose[wb] <= in_xpose;
        if (wr_row == LAST) begin
          wr_row   <= '0;
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (take) begin
        if (rd_idx == LAST) begin
          rd_idx   <= '0;
          full[rb] <= 1'b0;
          rb       <= ~rb;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  transpose_bank #(.DIM(DIM), .BITS(BITS), .IDX_W(IDX_W)) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept && !clr && !wb),
    .wr_idx (wr_row),
    .wr_vec (in_row),
    .rd_idx (rd_idx),
    .xpose  (xpose[0]),
    .rd_vec (vec0)
  );

  transpose_bank #(.DIM(DIM), .BITS(BITS), .IDX_W(IDX_W)) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept && !clr && wb),
    .wr_idx (wr_row),
    .wr_vec (in_row),
    .rd_idx (rd_idx),
    .xpose  (xpose[1]),
    .rd_vec (vec1)
  );

  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      out_col[r] = '0;
      if (out_valid) out_col[r] = rb ? vec1[r] : vec0[r];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_transpose_buffer.sv
// ---------------------------------------------------------------------------
// tb_transpose_buffer: directed scoreboard bench for transpose_buffer (DIM=4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_transpose_buffer;

  localparam int DIM  = 4;
  localparam int BITS = 16;

  typedef logic [DIM*BITS-1:0] flat_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clr;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [BITS-1:0] in_row [0:DIM-1];
  logic                   in_xpose;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [BITS-1:0] out_col [0:DIM-1];
  logic                   out_last;
  logic [1:0]             full_cnt;

  int    errors = 0;
  int    checks = 0;
  flat_t exp_q[$];
  bit    last_q[$];
  logic [BITS-1:0] tile [0:DIM-1][0:DIM-1];
  int    trow = 0;
  bit    tmode;
  flat_t prev_col;
  bit    hold_pending = 0;
  bit    acc;

  always #5 clk = ~clk;

  transpose_buffer #(.DIM(DIM), .BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_xpose  (in_xpose),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last),
    .full_cnt  (full_cnt)
  );

  function automatic flat_t flat_out();
    flat_t f;
    for (int r = 0; r < DIM; r++) f[r*BITS +: BITS] = out_col[r];
    return f;
  endfunction

  function automatic logic [BITS-1:0] elem_val(int kind, int base, int r, int c);
    if (kind == 0) return BITS'(base + 16*r + c);
    case ((r*DIM + c) % 3)
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      default: return BITS'(-(r*DIM + c + 2));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    trow = 0;
    exp_q.delete();
    last_q.delete();
    hold_pending = 0;
  endtask

  task automatic model_accept();
    flat_t f;
    if (trow == 0) tmode = in_xpose;
    for (int c = 0; c < DIM; c++) tile[trow][c] = in_row[c];
    trow++;
    if (trow == DIM) begin
      trow = 0;
      for (int k = 0; k < DIM; k++) begin
        for (int r = 0; r < DIM; r++) f[r*BITS +: BITS] = tmode ? tile[r][k] : tile[k][r];
        exp_q.push_back(f);
        last_q.push_back(k == DIM-1);
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    flat_t e;
    bit    l;
    #1;
    acc = 1'b0;
    if (hold_pending && out_valid) chk("hold_stable", flat_out(), prev_col);
    hold_pending = 0;
    if (!out_valid) chk("idle_zero", flat_out(), '0);
    if (clr) begin
      flush_model();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          chk("out_col", flat_out(), e);
          chk("out_last", out_last, l);
        end
      end else if (out_valid) begin
        prev_col     = flat_out();
        hold_pending = 1;
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        model_accept();
      end
    end
    @(negedge clk);
  endtask

  task automatic send_row(input int r, input int kind, input int base, input bit xp, input bit rnd);
    int n = 0;
    bit got = 0;
    for (int c = 0; c < DIM; c++) in_row[c] = elem_val(kind, base, r, c);
    in_xpose = xp;
    while (!got && n < 100) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      got = acc;
      n++;
    end
    in_valid = 1'b0;
    chk("accept_timeout", got, 1);
  endtask

  task automatic send_tile(input int kind, input int base, input bit xp, input bit rnd);
    for (int r = 0; r < DIM; r++) send_row(r, kind, base, xp, rnd);
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drained_idle", out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_col"}, flat_out(), '0);
    chk({tag, "_full_cnt"}, full_cnt, 0);
  endtask

  task automatic scenario_transpose();
    out_ready = 1'b1;
    for (int r = 0; r < DIM-1; r++) send_row(r, 0, 0, 1'b1, 1'b0);
    chk("pre_latency_valid", out_valid, 0);
    send_row(DIM-1, 0, 0, 1'b1, 1'b0);
    chk("latency_valid", out_valid, 1);
    chk("first_col_const", flat_out(), {16'd48, 16'd32, 16'd16, 16'd0});
    drain(1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_xpose  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < DIM; c++) in_row[c] = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Transposed tile, then same tile in pass-through order.
    scenario_transpose();
    out_ready = 1'b1;
    send_tile(0, 0, 1'b0, 1'b0);
    chk("pass_first_row", flat_out(), {16'd3, 16'd2, 16'd1, 16'd0});
    drain(1'b0);

    // Back-pressure: two tiles fill both banks, third waits.
    out_ready = 1'b0;
    send_tile(0, 100, 1'b1, 1'b0);
    send_tile(0, 200, 1'b0, 1'b0);
    chk("both_full_cnt", full_cnt, 2);
    chk("both_full_ready", in_ready, 0);
    for (int c = 0; c < DIM; c++) in_row[c] = elem_val(0, 300, 0, c);
    in_xpose  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < DIM; k++) begin
      chk("blocked_ready", in_ready, 0);
      tick();
    end
    chk("ready_after_last", in_ready, 1);
    send_tile(0, 300, 1'b1, 1'b0);
    drain(1'b0);

    // Negative data with random gaps on both sides.
    send_tile(1, 0, 1'b1, 1'b1);
    send_tile(1, 0, 1'b0, 1'b1);
    drain(1'b1);

    // clr with one full bank pending and a partial tile in flight.
    out_ready = 1'b0;
    send_tile(0, 700, 1'b1, 1'b0);
    send_row(0, 0, 500, 1'b1, 1'b0);
    send_row(1, 0, 500, 1'b1, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_full_cnt", full_cnt, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send_tile(0, 600, 1'b1, 1'b0);
    drain(1'b0);

    // Asynchronous reset while draining at rd_idx=2.
    out_ready = 1'b1;
    send_tile(0, 800, 1'b1, 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
    scenario_transpose();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/transpose_buffer.md
# transpose_buffer

Double-buffered, parametrised DIM×DIM tile transpose unit for the systolic matrix-multiply datapath. It accepts one DIM-wide row per cycle over a valid/ready handshake and emits one DIM-wide column per cycle over a second valid/ready handshake. Two banks let one tile fill while the other drains, so a steady stream runs at 1 row in and 1 column out per cycle. A per-tile mode bit selects transposed or pass-through (row-order) output. Sits between the weight/activation loader and the array edge feeders.

## Interface
- DIM, 8, tile dimension (rows = columns = lanes); ≥2
- BITS, 64, signed element width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: empties both banks, zeroes counters
- in_valid  in  1  in_row/in_xpose valid
- in_ready  out  1  buffer can accept a row this cycle
- in_row  in  signed [BITS-1:0] [0:DIM-1]  one tile row, lane c = column c
- in_xpose  in  1  tile mode, sampled on the tile's first accepted row: 1 = transpose, 0 = pass-through
- out_valid  out  1  out_col valid
- out_ready  in  1  consumer takes out_col this cycle
- out_col  out  signed [BITS-1:0] [0:DIM-1]  output vector, lane r
- out_last  out  1  out_col is the final vector of its tile
- full_cnt  out  2  number of full banks (0–2)

## Operation
- State: bank[0:1] of DIM×DIM elements; full[0:1]; xpose[0:1]; wb, rb (bank pointers); wr_row, rd_idx (counters, $clog2(DIM) bits).
- Accept = in_valid && in_ready. in_ready = !full[wb].
- On accept: bank[wb][wr_row][c] ← in_row[c] for all c; if wr_row==0 latch xpose[wb] ← in_xpose. wr_row increments; on wr_row==DIM-1 it wraps to 0, full[wb] ← 1, wb toggles.
- out_valid = full[rb]. out_col[r] = bank[rb][r][rd_idx] when xpose[rb]=1, bank[rb][rd_idx][r] when 0. out_col is all zeros when !out_valid.
- Take = out_valid && out_ready. On take rd_idx increments; on rd_idx==DIM-1 it wraps to 0, full[rb] ← 0, rb toggles.
- out_last = out_valid && rd_idx==DIM-1.
- full_cnt = full[0]+full[1].
- Accept into bank wb and take from bank rb in the same cycle are always legal; wb≠rb whenever both fire on a tile boundary, so both set/clear updates apply.
- in_valid deasserting mid-tile holds wr_row; out_ready low holds rd_idx and out_col stable.
- clr has priority over accept/take: full, wb, rb, wr_row, rd_idx ← 0; bank data and xpose untouched. Partial tile is discarded.
- Signed data is stored and forwarded bit-exact; no arithmetic.

## Timing
- Reset (rst_n low, async): bank data, full, xpose, pointers, counters ← 0. Outputs: in_ready=1, out_valid=0, out_last=0, out_col=0, full_cnt=0.
- Latency: the last row of a tile is accepted in cycle N; out_valid=1 with the first vector in cycle N+1.
- Throughput: with out_ready held high, continuous input never stalls: in_ready stays 1 indefinitely.
- Both banks full: in_ready=0 until the cycle after the draining bank's last take. in_ready is registered-state-derived; there is no same-cycle ready-through from out_ready.
- rst_n assertion mid-tile abandons all data immediately; first post-reset accept writes row 0 of bank 0.

## Structure
- Package transpose_pkg: elem_t (logic signed [BITS-1:0]); vec_t; IDX_W = $clog2(DIM) helper function.
- Sub-module transpose_bank: one DIM×DIM register array with row write port (we, row index, vector) and row/column read mux (index, xpose) → vector. Instantiated twice; top holds pointers, counters, flags, handshakes.

## Test plan
- DIM=4, BITS=16, element (r,c)=16r+c, xpose=1, out_ready=1: out_col sequence {0,16,32,48},{1,17,33,49},{2,…},{3,19,35,51}, out_last on the 4th, first out_valid one cycle after row 3 accepted.
- Same tile with xpose=0: out_col equals input rows in order {0,1,2,3}…{48,49,50,51}.
- Three back-to-back tiles, out_ready=0: in_ready drops after tile 2 (full_cnt=2); raise out_ready: tile 1 drains, in_ready returns the cycle after its out_last, tile 3 is accepted, order preserved.
- Negative data (-1, -32768) with random in_valid/out_ready gaps: output bit-exact, out_col stable while out_ready=0.
- clr after 2 rows of a tile: full_cnt=0, out_valid=0, in_ready=1; next 4 rows form a complete tile with correct output.
- rst_n pulse while draining rd_idx=2: all outputs return to reset values asynchronously; a fresh tile then behaves as in scenario 1.
